// File: rtl/sp_port_responder_pkg.sv
// Shared types and constants for sp_port_responder.
//   doorbell_state_t      : doorbell FSM state (IDLE, PENDING)
//   DOORBELL_COUNT_WIDTH  : width of the accepted-doorbell counter
//   READ_LATENCY_MIN/MAX  : legal range of the read pipeline depth
package sp_port_responder_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } doorbell_state_t;

  localparam int DOORBELL_COUNT_WIDTH = 16;
  localparam int READ_LATENCY_MIN     = 1;
  localparam int READ_LATENCY_MAX     = 3;

endpackage

// File: rtl/xpm_memory_tdpram_port_interface.sv
// One port of an XPM true-dual-port RAM.
//   clk  : port clock
//   rst  : synchronous read-pipeline reset
//   en   : access enable
//   we   : per-byte write enables
//   addr : word address
//   din  : write data
//   dout : read data (driven by the slave)
interface xpm_memory_tdpram_port_interface #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic                    clk;
  logic                    rst;
  logic                    en;
  logic [DATA_WIDTH/8-1:0] we;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   din;
  logic [DATA_WIDTH-1:0]   dout;

  modport master (output clk, rst, en, we, addr, din, input dout);
  modport slave  (input clk, rst, en, we, addr, din, output dout);
endinterface

// File: rtl/sp_port_responder_doorbell.sv
// Doorbell notifier: latches the word written to the doorbell address and
// presents it to the local processor with a valid/ready handshake.
//   clk_i, rst_ni : clock, async active-low reset
//   wr_i          : doorbell write this cycle
//   wr_data_i     : merged post-write word
//   ready_i       : consumer accepts the pending doorbell
//   ovf_clr_i     : clears the sticky overflow flag
//   valid_o       : doorbell pending
//   data_o        : latched doorbell word
//   overflow_o    : a pending doorbell was overwritten before acceptance
//   count_o       : accepted doorbells, wrapping
module sp_port_responder_doorbell
  import sp_port_responder_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            wr_i,
  input  logic [DATA_WIDTH-1:0]           wr_data_i,
  input  logic                            ready_i,
  input  logic                            ovf_clr_i,
  output logic                            valid_o,
  output logic [DATA_WIDTH-1:0]           data_o,
  output logic                            overflow_o,
  output logic [DOORBELL_COUNT_WIDTH-1:0] count_o
);

  doorbell_state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]           data_q, data_d;
  logic                            ovf_q, ovf_d;
  logic [DOORBELL_COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                            accept;

  assign accept = (state_q == PENDING) && ready_i;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    if (accept) cnt_d = cnt_q + DOORBELL_COUNT_WIDTH'(1);
    unique case (state_q)
      IDLE:    if (wr_i) state_d = PENDING;
      PENDING: if (accept && !wr_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Latest write wins; an accept in the same cycle hands off the old word.
    if (wr_i) data_d = wr_data_i;
    // Set has priority over clear.
    if (ovf_clr_i) ovf_d = 1'b0;
    if ((state_q == PENDING) && wr_i && !ready_i) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered only: no path from ready_i to valid_o.
  assign valid_o    = (state_q == PENDING);
  assign data_o     = data_q;
  assign overflow_o = ovf_q;
  assign count_o    = cnt_q;

endmodule

// File: rtl/sp_port_responder.sv
// Responder end of an XPM TDPRAM port: byte-enable, READ_FIRST memory with
// an XPM-style read pipeline, plus an optional doorbell word.
// Build option: SP_PORT_RESPONDER_DOORBELL_EN enables the doorbell; when
// undefined the doorbell outputs are 0 and DOORBELL_ADDR is plain memory.
//   clk, resetn           : clock, async active-low reset
//   port                  : TDPRAM port (slave side); port.clk is unused
//   doorbell_valid/ready  : doorbell handshake
//   doorbell_data         : merged word written to DOORBELL_ADDR
//   doorbell_overflow     : sticky overwrite flag, doorbell_overflow_clr clears
//   doorbell_count        : accepted-doorbell counter
module sp_port_responder
  import sp_port_responder_pkg::*;
#(
  parameter int ADDR_WIDTH    = 10,
  parameter int DATA_WIDTH    = 32,
  parameter int READ_LATENCY  = 2,
  parameter int DOORBELL_ADDR = (1 << ADDR_WIDTH) - 1
) (
  input  logic                            clk,
  input  logic                            resetn,
  xpm_memory_tdpram_port_interface.slave  port,
  output logic                            doorbell_valid,
  input  logic                            doorbell_ready,
  output logic [DATA_WIDTH-1:0]           doorbell_data,
  output logic                            doorbell_overflow,
  input  logic                            doorbell_overflow_clr,
  output logic [DOORBELL_COUNT_WIDTH-1:0] doorbell_count
);

  localparam int                    STROBE_WIDTH = DATA_WIDTH / 8;
  localparam int                    DEPTH        = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] DB_ADDR      = ADDR_WIDTH'(DOORBELL_ADDR);

  if (READ_LATENCY < READ_LATENCY_MIN || READ_LATENCY > READ_LATENCY_MAX) begin : g_bad_rl
    $error("sp_port_responder: READ_LATENCY must be 1..3");
  end
  if (DATA_WIDTH % 8 != 0) begin : g_bad_dw
    $error("sp_port_responder: DATA_WIDTH must be a multiple of 8");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word, wr_merged;

  logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] pipe_q, pipe_d;

  logic unused_port_clk;
  assign unused_port_clk = port.clk;

  assign rd_word = mem_q[port.addr];

  always_comb begin
    wr_merged = rd_word;
    for (int b = 0; b < STROBE_WIDTH; b++)
      if (port.we[b]) wr_merged[8*b +: 8] = port.din[8*b +: 8];
  end

  // Memory is never reset.
  always_ff @(posedge clk) begin
    if (port.en && (|port.we)) mem_q[port.addr] <= wr_merged;
  end

  // Stage 0 captures the pre-write word (READ_FIRST) and holds when idle;
  // later stages shift every cycle so dout settles on the last read.
  always_comb begin
    pipe_d = pipe_q;
    if (port.en) pipe_d[0] = rd_word;
    for (int i = 1; i < READ_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
    if (port.rst) pipe_d = '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) pipe_q <= '0;
    else         pipe_q <= pipe_d;
  end

  assign port.dout = pipe_q[READ_LATENCY-1];

`ifdef SP_PORT_RESPONDER_DOORBELL_EN
  logic db_wr;
  assign db_wr = port.en && (|port.we) && (port.addr == DB_ADDR);

  sp_port_responder_doorbell #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_doorbell (
    .clk_i      (clk),
    .rst_ni     (resetn),
    .wr_i       (db_wr),
    .wr_data_i  (wr_merged),
    .ready_i    (doorbell_ready),
    .ovf_clr_i  (doorbell_overflow_clr),
    .valid_o    (doorbell_valid),
    .data_o     (doorbell_data),
    .overflow_o (doorbell_overflow),
    .count_o    (doorbell_count)
  );
`else
  logic                  unused_db_in;
  logic [ADDR_WIDTH-1:0] unused_db_addr;
  assign unused_db_in      = doorbell_ready ^ doorbell_overflow_clr;
  assign unused_db_addr    = DB_ADDR;
  assign doorbell_valid    = 1'b0;
  assign doorbell_data     = '0;
  assign doorbell_overflow = 1'b0;
  assign doorbell_count    = '0;
`endif

endmodule

// File: tb/tb_sp_port_responder.sv
module tb_sp_port_responder;
  import sp_port_responder_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int RL = 2;
  localparam int DB = (1 << AW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        db_valid, db_ready, db_ovf, db_clr;
  logic [31:0] db_data;
  logic [15:0] db_count;

  xpm_memory_tdpram_port_interface #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) pif ();
  assign pif.clk = clk;

  sp_port_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL), .DOORBELL_ADDR(DB)
  ) dut (
    .clk(clk), .resetn(resetn), .port(pif),
    .doorbell_valid(db_valid), .doorbell_ready(db_ready), .doorbell_data(db_data),
    .doorbell_overflow(db_ovf), .doorbell_overflow_clr(db_clr), .doorbell_count(db_count)
  );

  // Doorbell sub-module exercised directly so it is covered in every build.
  logic        s_rst_n, s_wr, s_rdy, s_clr, s_valid, s_ovf;
  logic [31:0] s_d, s_dout;
  logic [15:0] s_cnt;

  sp_port_responder_doorbell #(.DATA_WIDTH(DW)) u_db (
    .clk_i(clk), .rst_ni(s_rst_n), .wr_i(s_wr), .wr_data_i(s_d), .ready_i(s_rdy),
    .ovf_clr_i(s_clr), .valid_o(s_valid), .data_o(s_dout), .overflow_o(s_ovf), .count_o(s_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural doorbell model ----------------
  typedef struct {
    bit          pend;
    logic [31:0] data;
    bit          ovf;
    logic [15:0] cnt;
  } db_m_t;

  function automatic db_m_t db_next(db_m_t s, bit wr, logic [31:0] d, bit rdy, bit clr);
    db_m_t n = s;
    if (s.pend && rdy) n.cnt = s.cnt + 16'd1;
    if (clr) n.ovf = 1'b0;
    if (wr) begin
      if (s.pend && !rdy) n.ovf = 1'b1;
      n.data = d;
      n.pend = 1'b1;
    end else if (s.pend && rdy) begin
      n.pend = 1'b0;
    end
    return n;
  endfunction

  function automatic db_m_t db_reset();
    db_m_t n;
    n.pend = 0; n.data = '0; n.ovf = 0; n.cnt = '0;
    return n;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit en, input logic [3:0] we, input int addr, input logic [31:0] din);
    pif.en   = en;
    pif.we   = we;
    pif.addr = AW'(addr);
    pif.din  = din;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_resetn();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  // ---------------- vector tables ----------------
  typedef struct {
    bit          en;
    logic [3:0]  we;
    int          addr;
    logic [31:0] din;
    bit          chk;
    logic [31:0] exp;
  } mvec_t;

  typedef struct {
    bit          wr;
    logic [31:0] d;
    bit          rdy;
    bit          clr;
    bit          ev;
    logic [31:0] ed;
    bit          eo;
    logic [15:0] ec;
  } dvec_t;

  mvec_t mtab[10];
  dvec_t dtab[12];

  logic [31:0] mmem [1024];
  logic [31:0] lr[$];
  int          rst_since;
  db_m_t       tm, sm;

  initial begin
    // Byte lanes, latency, READ_FIRST collision, hold.
    mtab[0] = '{1, 4'hF, 5, 32'hAABBCCDD, 0, 32'h0};
    mtab[1] = '{1, 4'h5, 5, 32'h11223344, 0, 32'h0};
    mtab[2] = '{1, 4'h0, 5, 32'h0,        1, 32'hAABBCCDD}; // write-cycle read-first still in flight
    mtab[3] = '{0, 4'h0, 0, 32'h0,        1, 32'hAA22CC44}; // RL edges after read en
    mtab[4] = '{1, 4'hF, 7, 32'h1,        1, 32'hAA22CC44};
    mtab[5] = '{1, 4'hF, 7, 32'h2,        0, 32'h0};        // write+read collision
    mtab[6] = '{1, 4'h0, 7, 32'h0,        1, 32'h1};        // collision returned old word
    mtab[7] = '{0, 4'h0, 0, 32'h0,        1, 32'h2};
    mtab[8] = '{0, 4'h0, 0, 32'h0,        1, 32'h2};
    mtab[9] = '{0, 4'h0, 0, 32'h0,        1, 32'h2};

    //           wr d      rdy clr  ev ed     eo ec
    dtab[0]  = '{1, 32'hCAFE, 0, 0, 1, 32'hCAFE, 0, 16'd0};
    dtab[1]  = '{0, 32'h0,    0, 0, 1, 32'hCAFE, 0, 16'd0};
    dtab[2]  = '{0, 32'h0,    0, 0, 1, 32'hCAFE, 0, 16'd0};
    dtab[3]  = '{0, 32'h0,    0, 0, 1, 32'hCAFE, 0, 16'd0};
    dtab[4]  = '{0, 32'h0,    1, 0, 0, 32'hCAFE, 0, 16'd1};
    dtab[5]  = '{1, 32'h1,    0, 0, 1, 32'h1,    0, 16'd1};
    dtab[6]  = '{1, 32'h2,    0, 0, 1, 32'h2,    1, 16'd1};
    dtab[7]  = '{1, 32'h3,    0, 1, 1, 32'h3,    1, 16'd1};
    dtab[8]  = '{0, 32'h0,    0, 1, 1, 32'h3,    0, 16'd1};
    dtab[9]  = '{1, 32'h4,    1, 0, 1, 32'h4,    0, 16'd2};
    dtab[10] = '{0, 32'h0,    1, 0, 0, 32'h4,    0, 16'd3};
    dtab[11] = '{1, 32'h5,    1, 0, 1, 32'h5,    0, 16'd3};

    resetn = 1'b0; pif.rst = 1'b0; drive(0, 0, 0, 0);
    db_ready = 0; db_clr = 0;
    s_rst_n = 1'b0; s_wr = 0; s_d = '0; s_rdy = 0; s_clr = 0;
    tick(); tick();

    // Reset state
    chk("rst_dout",     pif.dout, 0);
    chk("rst_db_valid", db_valid, 0);
    chk("rst_db_data",  db_data,  0);
    chk("rst_db_ovf",   db_ovf,   0);
    chk("rst_db_count", db_count, 0);
    chk("rst_s_valid",  s_valid,  0);
    chk("rst_s_cnt",    s_cnt,    0);
    resetn = 1'b1; s_rst_n = 1'b1;
    tick();

    // Memory table
    for (int i = 0; i < 10; i++) begin
      drive(mtab[i].en, mtab[i].we, mtab[i].addr, mtab[i].din);
      tick();
      if (mtab[i].chk) chk($sformatf("mem_tbl[%0d]", i), pif.dout, mtab[i].exp);
    end

    // port.rst zeroes the pipeline but not memory
    drive(0, 0, 0, 0); pif.rst = 1'b1;
    tick();
    chk("prst_dout_zero", pif.dout, 0);
    pif.rst = 1'b0;
    drive(1, 0, 5, 0); tick();
    chk("prst_latency", pif.dout, 0);
    drive(0, 0, 0, 0); tick();
    chk("prst_mem_kept", pif.dout, 32'hAA22CC44);

    // Doorbell sub-module table
    for (int i = 0; i < 12; i++) begin
      s_wr = dtab[i].wr; s_d = dtab[i].d; s_rdy = dtab[i].rdy; s_clr = dtab[i].clr;
      tick();
      chk($sformatf("db_tbl[%0d].valid", i), s_valid, dtab[i].ev);
      chk($sformatf("db_tbl[%0d].data", i),  s_dout,  dtab[i].ed);
      chk($sformatf("db_tbl[%0d].ovf", i),   s_ovf,   dtab[i].eo);
      chk($sformatf("db_tbl[%0d].count", i), s_cnt,   dtab[i].ec);
    end
    // Reset while pending aborts without counting
    s_wr = 1; s_d = 32'h77; s_rdy = 0; s_clr = 0; tick();
    s_wr = 0; s_rst_n = 1'b0; #1;
    chk("db_async_rst_valid", s_valid, 0);
    chk("db_async_rst_count", s_cnt, 0);
    tick(); s_rst_n = 1'b1; tick();

    // Doorbell sub-module randomized against model
    sm = db_reset();
    for (int n = 0; n < 2000; n++) begin
      bit rst_now;
      rst_now = ($urandom_range(0, 199) == 0);
      s_wr = ($urandom_range(0, 9) < 4); s_d = $urandom; s_rdy = $urandom_range(0, 1);
      s_clr = ($urandom_range(0, 7) == 0);
      if (rst_now) s_rst_n = 1'b0;
      tick();
      if (rst_now) begin sm = db_reset(); s_rst_n = 1'b1; end
      else sm = db_next(sm, s_wr, s_d, s_rdy, s_clr);
      chk("db_rand.valid", s_valid, sm.pend);
      chk("db_rand.data",  s_dout,  sm.data);
      chk("db_rand.ovf",   s_ovf,   sm.ovf);
      chk("db_rand.count", s_cnt,   sm.cnt);
    end

    // Counter wrap: wr+ready every cycle; first edge only enters PENDING.
    s_rst_n = 1'b0; s_wr = 0; s_rdy = 0; s_clr = 0; tick(); s_rst_n = 1'b1;
    s_wr = 1; s_rdy = 1; s_d = 32'h5A;
    repeat (65536) @(posedge clk);
    #1;
    chk("db_wrap_ffff", s_cnt, 16'hFFFF);
    tick();
    chk("db_wrap_zero", s_cnt, 16'h0000);
    chk("db_wrap_valid", s_valid, 1);
    s_wr = 0; s_rdy = 0;

    // Top randomized run against the behavioural model
    for (int a = 0; a < 16; a++) begin
      mmem[a] = $urandom; drive(1, 4'hF, a, mmem[a]); tick();
    end
    mmem[DB] = $urandom; drive(1, 4'hF, DB, mmem[DB]); tick();
    drive(0, 0, 0, 0);
    pulse_resetn();
    tm = db_reset(); lr.delete(); lr.push_back('0); rst_since = 0;
    for (int n = 0; n < 3000; n++) begin
      bit          en, rst, dbw;
      logic [3:0]  we;
      int          addr;
      logic [31:0] din, old, mrg;
      en   = ($urandom_range(0, 3) != 0);
      we   = ($urandom_range(0, 9) < 3) ? 4'h0 : 4'($urandom);
      addr = ($urandom_range(0, 7) == 0) ? DB : $urandom_range(0, 15);
      din  = $urandom;
      rst  = ($urandom_range(0, 49) == 0);
      drive(en, we, addr, din); pif.rst = rst;
      db_ready = $urandom_range(0, 1); db_clr = ($urandom_range(0, 7) == 0);
      old = mmem[addr];
      mrg = old;
      for (int b = 0; b < 4; b++) if (we[b]) mrg[8*b +: 8] = din[8*b +: 8];
      dbw = en && (we != 0) && (addr == DB);
      tick();
      if (en && we != 0) mmem[addr] = mrg;
      if (rst) begin lr.push_back('0); rst_since = 0; end
      else begin lr.push_back(en ? old : lr[$]); rst_since++; end
      if (lr.size() > 8) void'(lr.pop_front());
      chk("top_rand.dout", pif.dout, (rst_since < RL - 1) ? 32'h0 : lr[lr.size() - RL]);
`ifdef SP_PORT_RESPONDER_DOORBELL_EN
      tm = db_next(tm, dbw, mrg, db_ready, db_clr);
      chk("top_rand.db_valid", db_valid, tm.pend);
      chk("top_rand.db_data",  db_data,  tm.data);
      chk("top_rand.db_ovf",   db_ovf,   tm.ovf);
      chk("top_rand.db_count", db_count, tm.cnt);
`else
      chk("top_rand.db_off", {db_valid, db_ovf, db_data, db_count}, {dbw, 49'h0} & 50'h0);
`endif
    end
    drive(0, 0, 0, 0); pif.rst = 0; db_ready = 0; db_clr = 0;
    pulse_resetn();

`ifdef SP_PORT_RESPONDER_DOORBELL_EN
    drive(1, 4'hF, DB, 32'hCAFE); tick();
    chk("top_db_valid", db_valid, 1);
    chk("top_db_data",  db_data,  32'hCAFE);
    drive(0, 0, 0, 0);
    repeat (3) tick();
    chk("top_db_hold", db_valid, 1);
    db_ready = 1; tick(); db_ready = 0;
    chk("top_db_ack_valid", db_valid, 0);
    chk("top_db_ack_count", db_count, 1);
    drive(1, 4'hF, DB, 32'h1); tick();
    drive(1, 4'hF, DB, 32'h2); tick();
    chk("top_ovf_data", db_data, 32'h2);
    chk("top_ovf_flag", db_ovf, 1);
    drive(1, 4'hF, DB, 32'h3); db_clr = 1; tick(); db_clr = 0;
    chk("top_ovf_clr_vs_set", db_ovf, 1);
    drive(1, 4'h1, DB, 32'hEE); db_ready = 1; tick(); db_ready = 0;
    chk("top_ackwr_valid", db_valid, 1);
    chk("top_ackwr_data",  db_data,  32'hEE);
    chk("top_ackwr_count", db_count, 2);
    drive(0, 0, 0, 0);
    pulse_resetn();
    chk("top_rst_pend_valid", db_valid, 0);
    chk("top_rst_pend_count", db_count, 0);
`else
    drive(1, 4'hF, DB, 32'h1234); tick();
    chk("top_nodb_valid", db_valid, 0);
    drive(1, 4'h0, DB, 0); tick();
    drive(0, 0, 0, 0); tick();
    chk("top_nodb_readback", pif.dout, 32'h1234);
    chk("top_nodb_count", db_count, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sp_port_responder.md
# sp_port_responder

Slave (responder) end of the `xpm_memory_tdpram_port_interface` port: a synthesizable memory that answers a port master with XPM-compatible read latency and byte-enable writes. It replaces a real XPM TDPRAM port in simulation-friendly fabric builds and adds a doorbell word. A write to the doorbell address raises a valid/ready notification toward the local processor. It sits between a port master (e.g. a DMA or RX/TX engine) and the stream processor's control logic.

## Interface
- `ADDR_WIDTH`, 10: word address width; the memory depth is 2^ADDR_WIDTH words.
- `DATA_WIDTH`, 32: word width; a multiple of 8, with STROBE_WIDTH = DATA_WIDTH/8.
- `READ_LATENCY`, 2: cycles from read-enable to `dout`; legal values 1..3.
- `DOORBELL_ADDR`, 2^ADDR_WIDTH-1: word address that triggers the doorbell.
- `clk`  in  1  block clock; `port.clk` is driven from the same net and otherwise ignored.
- `resetn`  in  1  asynchronous, active-low reset.
- `port`  modport  `xpm_memory_tdpram_port_interface.slave`, with the parameters above.
- `doorbell_valid`  out  1  doorbell pending.
- `doorbell_ready`  in  1  consumer accepts the doorbell.
- `doorbell_data`  out  DATA_WIDTH  word written to DOORBELL_ADDR, after merging.
- `doorbell_overflow`  out  1  sticky: a doorbell was overwritten before it was accepted.
- `doorbell_overflow_clr`  in  1  clears `doorbell_overflow`.
- `doorbell_count`  out  16  accepted-doorbell counter; wraps from 0xFFFF to 0.

## Operation
- Memory access is defined only when `port.en`=1.
  - For each byte lane b with `port.we[b]`=1, memory byte b at `port.addr` takes `port.din` byte b.
  - Lanes with `we[b]`=0 keep their memory value.
- Write mode is READ_FIRST. A read and a write to the same address in the same cycle return the old word.
- Read pipeline:
  - Stage 0 loads mem[addr] when `en`=1 and holds otherwise.
  - Stages 1..READ_LATENCY-1 shift on every cycle.
  - `port.dout` is the last stage. With no new reads, `dout` holds its value.
- `port.rst`=1 synchronously zeroes all pipeline stages. Memory contents are unaffected.
- Doorbell FSM, states IDLE and PENDING:
  - A doorbell write is `en`=1, `we`≠0 and `addr`=DOORBELL_ADDR.
  - `doorbell_data` is the merged post-write word.
  - IDLE + doorbell write → PENDING; `doorbell_data` is latched.
  - PENDING + `doorbell_ready` with no new write → IDLE; `doorbell_count`+1.
  - PENDING + `doorbell_ready` + new write → stays PENDING with the new data; count+1; no overflow.
  - PENDING + new write without ready → stays PENDING; data is overwritten (latest wins); `doorbell_overflow` is set.
  - `doorbell_overflow_clr` together with an overflow event in the same cycle: the set wins.
- A write with `we`=0 to DOORBELL_ADDR is a read and does not ring the doorbell.

## Timing
- Reset (`resetn`=0):
  - `port.dout`=0, all pipeline stages 0.
  - State IDLE, `doorbell_valid`=0, `doorbell_data`=0, `doorbell_overflow`=0, `doorbell_count`=0.
  - Memory contents are not reset.
  - Asserting reset mid-operation aborts any pending doorbell without incrementing the count.
- Read latency: `en` at edge N → `dout` valid after edge N+READ_LATENCY.
- Writes are visible to a read issued at edge N+1 or later.
- Doorbell: a write at edge N → `doorbell_valid`=1 after edge N.
- Handshake: transfer on `valid`&&`ready` at a rising edge. `doorbell_data` is stable while `valid`=1 unless overwritten by a new write, which counts as an overflow.
- `doorbell_valid` has no combinational path from `doorbell_ready`.

## Configuration
- `SP_PORT_RESPONDER_DOORBELL_EN` defined: the doorbell FSM, counter and outputs are present as specified.
- Not defined:
  - The doorbell outputs are tied to 0 and `doorbell_ready`/`doorbell_overflow_clr` are ignored.
  - DOORBELL_ADDR is ordinary memory.
  - Memory and read-pipeline behaviour is unchanged.

## Structure
- Package `sp_port_responder_pkg`:
  - `doorbell_state_t` enum (IDLE, PENDING).
  - `DOORBELL_COUNT_WIDTH`=16.
  - `READ_LATENCY_MIN`=1 and `READ_LATENCY_MAX`=3.
- An elaboration-time check rejects READ_LATENCY outside the legal range and DATA_WIDTH not a multiple of 8.
- One sub-module, `sp_port_responder_doorbell`, holds the FSM, data latch, overflow flag and counter. The top module holds the memory and the read pipeline.

## Test plan
- Byte-lane write: write 0xAABBCCDD to addr 5 with `we`=0xF, then 0x11223344 with `we`=0x5; read addr 5 → 0xAA22CC44 exactly READ_LATENCY cycles after `en`.
- Collision and hold: at addr 7 holding 0x1, write 0x2 and read in the same cycle → `dout`=0x1. Read again → 0x2. Idle `en` → `dout` holds 0x2.
- Doorbell handshake: write 0xCAFE to DOORBELL_ADDR → `valid`=1 next cycle with data 0xCAFE. `ready` held low 3 cycles keeps valid; `ready`=1 → valid=0 and count=1.
- Overflow:
  - Two doorbell writes (0x1, then 0x2) without ready → data=0x2, overflow=1.
  - `overflow_clr` plus a third write in the same cycle → overflow stays 1.
  - Ack plus a new write in the same cycle → valid stays 1, count increments.
- Resets:
  - `port.rst` pulse zeroes `dout` while the memory keeps its data.
  - `resetn` asserted while PENDING → valid=0, count=0.
  - With the macro undefined, a write to DOORBELL_ADDR reads back normally and `doorbell_valid` stays 0.
